// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module      : instr_mem_loader
// Description : Assembles big-endian instruction words from a UART byte stream
//               and writes them into instruction memory until HALT or overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader #(
    parameter int               NBITS     = 32,
    parameter int               NBYTE     = 8,
    parameter int               CELDAS    = 60,
    parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_rx_done,
    input  logic [NBYTE-1:0] i_rx_data,
    output logic             o_wr_en,
    output logic [NBITS-1:0] o_wr_addr,
    output logic [NBITS-1:0] o_wr_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [NBITS-1:0] o_word_count
);

    localparam int               C_BPW       = NBITS / NBYTE;
    localparam int               C_CNTW      = (C_BPW > 1) ? $clog2(C_BPW) : 1;
    localparam logic [C_CNTW-1:0] C_LAST_BYTE = C_CNTW'(C_BPW - 1);
    localparam logic [C_CNTW-1:0] C_CNT_ONE   = C_CNTW'(1);
    localparam logic [NBITS-1:0] C_CELDAS    = NBITS'(CELDAS);
    localparam logic [NBITS-1:0] C_ADDR_STEP = NBITS'(4);
    localparam logic [NBITS-1:0] C_ONE       = NBITS'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t             r_state;
    logic [NBITS-1:0]   r_word;
    logic [C_CNTW-1:0]  r_byte_cnt;
    logic [NBITS-1:0]   r_addr;
    logic               r_wr_en;
    logic [NBITS-1:0]   r_wr_addr;
    logic [NBITS-1:0]   r_wr_data;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [NBITS-1:0]   r_word_count;

    logic [NBITS-1:0]   w_word_next;
    logic [NBITS-1:0]   w_addr_next;

    // First byte of a word ends up in the MSB after all shifts.
    assign w_word_next = {r_word[NBITS-NBYTE-1:0], i_rx_data};
    assign w_addr_next = r_addr + C_ADDR_STEP;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_word       <= '0;
            r_byte_cnt   <= '0;
            r_addr       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (i_start) begin
                // Restart from any state; a simultaneous byte is discarded.
                r_state      <= S_LOAD;
                r_word       <= '0;
                r_byte_cnt   <= '0;
                r_addr       <= '0;
                r_word_count <= '0;
                r_busy       <= 1'b1;
                r_done       <= 1'b0;
                r_error      <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (i_rx_done) begin
                            r_word <= w_word_next;
                            if (r_byte_cnt == C_LAST_BYTE) begin
                                r_byte_cnt   <= '0;
                                r_state      <= S_WRITE;
                                r_wr_en      <= 1'b1;
                                r_wr_addr    <= r_addr;
                                r_wr_data    <= w_word_next;
                                r_word_count <= r_word_count + C_ONE;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + C_CNT_ONE;
                            end
                        end
                    end
                    S_WRITE: begin
                        // A byte arriving now is the first byte of the next word.
                        if (i_rx_done) begin
                            r_word     <= w_word_next;
                            r_byte_cnt <= C_CNT_ONE;
                        end
                        if (r_word == HALT_WORD) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_addr_next >= C_CELDAS) begin
                            r_state <= S_ERROR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_addr  <= w_addr_next;
                            r_state <= S_LOAD;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Self-checking bench for instr_mem_loader (vector table,
//               directed corner sequences and randomized model comparison).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_mem_loader;

    localparam int          CELDAS = 60;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic        i_start = 1'b0;
    logic        i_rx_done = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        o_wr_en, o_busy, o_done, o_error;
    logic [31:0] o_wr_addr, o_wr_data, o_word_count;

    int checks = 0;
    int errors = 0;

    instr_mem_loader dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_word_count (o_word_count)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Reference model: loader modes and a queue of bytes for the current word.
    typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mode_t;
    mode_t       m_mode;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_addr, m_count, m_last_addr, m_last_data;
    logic        m_wr;

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_bytes.delete();
        m_addr = 0; m_count = 0; m_last_addr = 0; m_last_data = 0; m_wr = 0;
    endfunction

    function automatic void model_step(input logic s, input logic r, input logic [7:0] d);
        logic [31:0] word;
        m_wr = 1'b0;
        if (s) begin
            m_mode = M_LOAD;
            m_bytes.delete();
            m_addr = 0;
            m_count = 0;
        end else if (m_mode == M_LOAD && r) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
                word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_bytes.delete();
                m_wr = 1'b1;
                m_last_addr = m_addr;
                m_last_data = word;
                m_count = m_count + 1;
                if (word == HALT)                 m_mode = M_DONE;
                else if (m_addr + 4 >= CELDAS)   m_mode = M_ERR;
                else                              m_addr = m_addr + 4;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_check();
        logic exp_busy, exp_done, exp_err;
        exp_busy = (m_mode == M_LOAD) || m_wr;
        exp_done = (m_mode == M_DONE) && !m_wr;
        exp_err  = (m_mode == M_ERR)  && !m_wr;
        checks++;
        if (o_wr_en !== m_wr || o_busy !== exp_busy || o_done !== exp_done ||
            o_error !== exp_err || o_wr_addr !== m_last_addr ||
            o_wr_data !== m_last_data || o_word_count !== m_count) begin
            errors++;
            $display("FAIL model @%0t: got wr=%b busy=%b done=%b err=%b addr=%h data=%h cnt=%0d expected wr=%b busy=%b done=%b err=%b addr=%h data=%h cnt=%0d",
                     $time, o_wr_en, o_busy, o_done, o_error, o_wr_addr, o_wr_data, o_word_count,
                     m_wr, exp_busy, exp_done, exp_err, m_last_addr, m_last_data, m_count);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
    task automatic tick(input logic s, input logic r, input logic [7:0] d);
        i_start = s; i_rx_done = r; i_rx_data = d;
        model_step(s, r, d);
        @(posedge i_clk); #1;
        i_start = 1'b0; i_rx_done = 1'b0;
        model_check();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, w[31-8*k -: 8]);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {28'd0, o_wr_en, o_busy, o_done, o_error}, 32'd0);
        chk({name, "_addr"}, o_wr_addr, 32'd0);
        chk({name, "_data"}, o_wr_data, 32'd0);
        chk({name, "_cnt"}, o_word_count, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    typedef struct {
        logic        start;
        logic        rx;
        logic [7:0]  data;
        logic        ewr;
        logic [31:0] eaddr;
        logic [31:0] edata;
        logic        edone;
        logic [31:0] ecnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Basic load with back-to-back strobes, one strobe landing in WRITE.
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0,         1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h8D, 1'b0, 32'h0, 32'h0,         1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 8'hC2, 1'b0, 32'h0, 32'h0,         1'b0, 32'd0};
        tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 32'h0, 32'h0,         1'b0, 32'd0};
        tbl[4]  = '{1'b0, 1'b1, 8'h02, 1'b1, 32'h0, 32'h8DC20002,  1'b0, 32'd1};
        tbl[5]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h0, 32'h8DC20002,  1'b0, 32'd1};
        tbl[6]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h0, 32'h8DC20002,  1'b0, 32'd1};
        tbl[7]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h0, 32'h8DC20002,  1'b0, 32'd1};
        tbl[8]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 32'h4, 32'hFFFFFFFF,  1'b0, 32'd2};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h4, 32'hFFFFFFFF,  1'b1, 32'd2};
        tbl[10] = '{1'b0, 1'b1, 8'h11, 1'b0, 32'h4, 32'hFFFFFFFF,  1'b1, 32'd2};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h4, 32'hFFFFFFFF,  1'b1, 32'd2};

        // Power-on reset
        #2 i_reset_n = 1'b0;
        #1 check_all_zero("reset");
        model_reset();
        release_reset();

        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].start, tbl[i].rx, tbl[i].data);
            checks++;
            if (o_wr_en !== tbl[i].ewr || o_wr_addr !== tbl[i].eaddr ||
                o_wr_data !== tbl[i].edata || o_done !== tbl[i].edone ||
                o_word_count !== tbl[i].ecnt) begin
                errors++;
                $display("FAIL vec%0d: got wr=%b addr=%h data=%h done=%b cnt=%0d expected wr=%b addr=%h data=%h done=%b cnt=%0d",
                         i, o_wr_en, o_wr_addr, o_wr_data, o_done, o_word_count,
                         tbl[i].ewr, tbl[i].eaddr, tbl[i].edata, tbl[i].edone, tbl[i].ecnt);
            end
        end

        // Asynchronous reset after two bytes of a word, then bytes without start.
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h12);
        tick(1'b0, 1'b1, 8'h34);
        #3 i_reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        release_reset();
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 8'($urandom));
        chk("no_write_after_reset_cnt", o_word_count, 32'd0);

        // Overflow: fifteen non-HALT words fill addresses 0..56.
        tick(1'b1, 1'b0, 8'h00);
        for (int w = 0; w < 15; w++) send_word({8'(w), 24'h00A5A5});
        chk("ovf_last_addr", o_wr_addr, 32'd56);
        tick(1'b0, 1'b0, 8'h00);
        chk("ovf_error", {31'd0, o_error}, 32'd1);
        chk("ovf_count", o_word_count, 32'd15);
        send_word(32'h0102_0304);
        chk("ovf_ignored", o_word_count, 32'd15);

        // Restart after three bytes of the second word.
        tick(1'b1, 1'b0, 8'h00);
        send_word(32'hDEAD_BEEF);
        tick(1'b0, 1'b1, 8'hAA);
        tick(1'b0, 1'b1, 8'hBB);
        tick(1'b0, 1'b1, 8'hCC);
        tick(1'b1, 1'b0, 8'h00);
        send_word(32'h1357_9BDF);
        chk("restart_addr", o_wr_addr, 32'd0);
        chk("restart_data", o_wr_data, 32'h1357_9BDF);
        chk("restart_cnt", o_word_count, 32'd1);

        // Start together with a byte: the byte is discarded.
        tick(1'b1, 1'b1, 8'hAA);
        send_word(32'h0102_0304);
        chk("start_discard", o_wr_data, 32'h0102_0304);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic s, r;
            logic [7:0] d;
            s = ($urandom_range(0, 99) < 3);
            r = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            tick(s, r, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
